// File: rtl/rx_frame.sv
// 8N1 UART receiver that assembles NUM_BYTES bytes into a 162-bit word with
// a one-cycle valid strobe, plus stop-bit and mid-frame idle timeout errors.
module rx_frame #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int DIVISOR       = CLK_HZ / BAUD_RATE,
    parameter int NUM_BYTES     = 21,
    parameter int TIMEOUT_BAUDS = 40
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         data_in,
    output logic [161:0] val_out,
    output logic         valid_out,
    output logic         frame_err_out,
    output logic         timeout_err_out
);

    localparam int CNT_W      = $clog2(DIVISOR);
    localparam int IDLE_LIMIT = TIMEOUT_BAUDS * DIVISOR;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
    localparam int IDX_W      = $clog2(NUM_BYTES + 1);
    localparam int SLOT_W     = 8 * (NUM_BYTES - 1);
    localparam int TAIL_W     = 162 - SLOT_W;

    localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(DIVISOR - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t              state_r, state_n_s;
    logic                sync1_r, rx_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          shift_r;
    logic [IDX_W-1:0]    idx_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [SLOT_W-1:0]   slot_r;
    logic                tick_s, start_s, sample_s, byte_ok_s, stop_bad_s;
    logic                idle_run_s, frame_done_s, tout_s;

    assign tick_s = (cnt_r == {CNT_W{1'b0}});

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_r <= 1'b1;
            rx_r    <= 1'b1;
        end else begin
            sync1_r <= data_in;
            rx_r    <= sync1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE:  if (!rx_r) state_n_s = ST_START; else state_n_s = ST_IDLE;
            ST_START: if (tick_s) state_n_s = rx_r ? ST_IDLE : ST_DATA; else state_n_s = ST_START;
            ST_DATA:  if (tick_s && (bit_cnt_r == 3'd7)) state_n_s = ST_STOP; else state_n_s = ST_DATA;
            ST_STOP:  if (tick_s) state_n_s = rx_r ? ST_IDLE : ST_BREAK; else state_n_s = ST_STOP;
            ST_BREAK: if (rx_r) state_n_s = ST_IDLE; else state_n_s = ST_BREAK;
            default:  state_n_s = ST_IDLE;
        endcase
    end

    // FSM control strobes; a start edge always beats an expiring idle timer.
    always_comb begin
        start_s    = 1'b0;
        sample_s   = 1'b0;
        byte_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
        idle_run_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s    = !rx_r;
                idle_run_s = rx_r && (idx_r != {IDX_W{1'b0}});
            end
            ST_DATA: sample_s = tick_s;
            ST_STOP: begin
                byte_ok_s  = tick_s && rx_r;
                stop_bad_s = tick_s && !rx_r;
            end
            default: start_s = 1'b0;
        endcase
        frame_done_s = byte_ok_s && (idx_r == LAST_IDX);
        tout_s       = idle_run_s && (idle_cnt_r == IDLE_LAST);
    end

    // Baud counter, bit counter and byte shift register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            if (start_s) begin
                cnt_r <= HALF_LOAD;
            end else if ((state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP)) begin
                cnt_r <= tick_s ? FULL_LOAD : (cnt_r - CNT_W'(1));
            end else begin
                cnt_r <= cnt_r;
            end
            if (start_s) begin
                bit_cnt_r <= 3'd0;
            end else if (sample_s) begin
                bit_cnt_r <= (bit_cnt_r == 3'd7) ? 3'd0 : (bit_cnt_r + 3'd1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (sample_s) begin
                shift_r <= {rx_r, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Byte slots, byte index and idle timer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_r     <= {SLOT_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else begin
            for (int k = 0; k < NUM_BYTES - 1; k++) begin
                if (byte_ok_s && (idx_r == IDX_W'(k))) begin
                    slot_r[8*k +: 8] <= shift_r;
                end
            end
            if (stop_bad_s || tout_s || frame_done_s) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (byte_ok_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            if (idle_run_s && !tout_s) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_r <= {IDLE_W{1'b0}};
            end
        end
    end

    // Registered outputs; the last byte contributes only its low TAIL_W bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_out         <= 162'd0;
            valid_out       <= 1'b0;
            frame_err_out   <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            if (frame_done_s) begin
                val_out <= {shift_r[TAIL_W-1:0], slot_r};
            end else begin
                val_out <= val_out;
            end
            valid_out       <= frame_done_s;
            frame_err_out   <= stop_bad_s;
            timeout_err_out <= tout_s;
        end
    end

endmodule

// File: tb/tb_rx_frame.sv
// Self-checking bench for rx_frame at DIVISOR=16: table-driven frames plus
// hand-written glitch, bad-stop, timeout, mid-byte reset and held-low cases.
module tb_rx_frame;
    localparam int DIV = 16;
    localparam int NB  = 21;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         data;
    logic [161:0] val;
    logic         valid, ferr, tout;

    always #5 clk = ~clk;

    rx_frame #(
        .CLK_HZ(160_000), .BAUD_RATE(10_000), .DIVISOR(DIV),
        .NUM_BYTES(NB), .TIMEOUT_BAUDS(40)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .val_out(val),
        .valid_out(valid), .frame_err_out(ferr), .timeout_err_out(tout)
    );

    typedef struct {
        logic [7:0]   first;
        logic [7:0]   step;
        int           gap_bits;
        logic [161:0] exp;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [161:0] exp_q[$];
    logic [161:0] got_q[$];
    int           got_rd = 0;
    int           ferr_cnt = 0, tout_cnt = 0, overlap_cnt = 0;
    logic [161:0] last_exp;

    // Output monitor: records every completed word and counts error pulses.
    always @(negedge clk) begin
        if (valid) got_q.push_back(val);
        if (ferr) ferr_cnt++;
        if (tout) tout_cnt++;
        if (valid && ferr) overlap_cnt++;
    end

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        data = 1'b0;
        ticks(DIV);
        for (int i = 0; i < 8; i++) begin
            data = b[i];
            ticks(DIV);
        end
        data = stop_bit;
        ticks(DIV);
        data = 1'b1;
    endtask

    function automatic logic [161:0] build(input logic [7:0] first, input logic [7:0] step);
        logic [167:0] full;
        full = 168'd0;
        for (int k = 0; k < NB; k++) full[8*k +: 8] = first + 8'(k) * step;
        return full[161:0];
    endfunction

    task automatic send_frame(input logic [7:0] first, input logic [7:0] step, input int gap_bits);
        exp_q.push_back(build(first, step));
        for (int k = 0; k < NB; k++) begin
            send_byte(first + 8'(k) * step, 1'b1);
            ticks(gap_bits * DIV);
        end
    endtask

    task automatic wait_frame(input string name);
        logic [161:0] e;
        int budget;
        budget = 0;
        while ((got_rd >= got_q.size()) && (budget < 200)) begin
            ticks(1);
            budget++;
        end
        e = exp_q.pop_front();
        last_exp = e;
        if (got_rd >= got_q.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no valid_out within 200 cycles, expected %h", name, e);
        end else begin
            chk(name, got_q[got_rd], e);
            got_rd++;
        end
    endtask

    initial begin
        vec_t tbl[4];
        logic [161:0] g;
        logic [7:0]   b;
        tbl[0] = '{8'h00, 8'h01, 0, 162'd0};
        tbl[1] = '{8'h5A, 8'h11, 2, 162'd0};
        tbl[2] = '{8'h80, 8'h03, 1, 162'd0};
        tbl[3] = '{8'hFF, 8'hFF, 0, 162'd0};
        for (int i = 0; i < 4; i++) tbl[i].exp = build(tbl[i].first, tbl[i].step);

        rst_n = 1'b0;
        data  = 1'b1;
        ticks(4);
        chk("reset val_out", val, 162'd0);
        chk_i("reset valid_out", int'(valid), 0);
        chk_i("reset frame_err_out", int'(ferr), 0);
        chk_i("reset timeout_err_out", int'(tout), 0);
        rst_n = 1'b1;
        ticks(2 * DIV);

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].first, tbl[i].step, tbl[i].gap_bits);
            wait_frame($sformatf("table frame %0d", i));
            chk($sformatf("table frame %0d vs record", i), last_exp, tbl[i].exp);
            if (i == 0) begin
                g = got_q[got_rd-1];
                chk_i("frame0 byte0", int'(g[7:0]), 8'h00);
                chk_i("frame0 byte1", int'(g[15:8]), 8'h01);
                chk_i("frame0 bits161:160", int'(g[161:160]), 0);
            end
            chk_i($sformatf("table frame %0d no frame_err", i), ferr_cnt, 0);
            chk_i($sformatf("table frame %0d no timeout", i), tout_cnt, 0);
            ticks(DIV);
        end

        // Short low glitch: false start, nothing recorded.
        data = 1'b0;
        ticks(6);
        data = 1'b1;
        ticks(3 * DIV);
        chk_i("glitch no frame_err", ferr_cnt, 0);
        send_frame(8'h10, 8'h01, 0);
        wait_frame("frame after glitch");

        // Bad stop bit, then a frame of all ones.
        ticks(DIV);
        send_byte(8'hA5, 1'b0);
        ticks(3 * DIV);
        chk_i("bad stop frame_err count", ferr_cnt, 1);
        chk_i("bad stop no valid", got_q.size(), got_rd);
        send_frame(8'hFF, 8'h00, 0);
        wait_frame("all-ones frame after bad stop");

        // Partial frame dropped on idle timeout.
        ticks(DIV);
        for (int k = 0; k < 5; k++) begin
            b = 8'h21 + 8'(k);
            send_byte(b, 1'b1);
        end
        ticks(40 * DIV + 5);
        chk_i("timeout pulse count", tout_cnt, 1);
        chk("val_out held over timeout", val, last_exp);
        send_frame(8'h3C, 8'h00, 0);
        wait_frame("0x3C frame after timeout");
        chk_i("single timeout pulse", tout_cnt, 1);

        // Reset during bit 4 of byte 10.
        ticks(DIV);
        for (int k = 0; k < 10; k++) begin
            b = 8'(k);
            send_byte(b, 1'b1);
        end
        b = 8'h5A;
        data = 1'b0;
        ticks(DIV);
        for (int i = 0; i < 4; i++) begin
            data = b[i];
            ticks(DIV);
        end
        data = b[4];
        ticks(DIV / 2);
        rst_n = 1'b0;
        ticks(1);
        chk("mid-byte reset val_out", val, 162'd0);
        chk_i("mid-byte reset pulses", int'(valid) + int'(ferr) + int'(tout), 0);
        data = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        ticks(3 * DIV);
        send_frame(8'hC3, 8'h05, 0);
        wait_frame("frame after reset");
        chk_i("no spurious frame_err after reset", ferr_cnt, 1);
        chk_i("no spurious timeout after reset", tout_cnt, 1);

        // Line held low for 300 cycles.
        ticks(DIV);
        data = 1'b0;
        ticks(300);
        data = 1'b1;
        ticks(2 * DIV);
        chk_i("held-low frame_err count", ferr_cnt, 2);
        chk_i("held-low no valid", got_q.size(), got_rd);
        send_frame(8'h01, 8'h0B, 0);
        wait_frame("frame after held low");

        ticks(4 * DIV);
        chk_i("no extra valid pulses", got_q.size(), got_rd);
        chk_i("final frame_err count", ferr_cnt, 2);
        chk_i("final timeout count", tout_cnt, 1);
        chk_i("valid/frame_err overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
